microwave_ctrl_v2: RTL

MICROWAVE_CTRL_V2 -- requirements
Module: microwave_ctrl_v2

---
 rtl/microwave_ctrl_v2.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/microwave_ctrl_v2.sv
// microwave_ctrl_v2: microwave oven controller with BCD keypad entry, countdown timer and 7-segment display
// Ports: clock, resetn (async active-low); keypad[9:0] one-hot digit; startn/stopn/clearn active-low buttons;
//        door_closed; power_level[3:0] in tenths; sec_ones_segs/sec_tens_segs/mins_segs gfedcba segments;
//        mag_on magnetron enable; done one-cycle completion pulse; state_o (IDLE=0, COOK=1, PAUSE=2).
// Optional: define MICROWAVE_POWER_LEVEL_EN to duty-cycle mag_on by power_level within each second.
module microwave_ctrl_v2 #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MIN_DIGITS    = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    input  logic [3:0]              power_level,
    output logic [6:0]              sec_ones_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0] mins_segs,
    output logic                    mag_on,
    output logic                    done,
    output logic [1:0]              state_o
);
    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam logic [6:0] ZERO_SEG = 7'b0111111;
    typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2} state_t;
    state_t                       state;
    logic [3:0]                   s1, s10;
    logic [MIN_DIGITS-1:0][3:0]   mins;
    logic [TW-1:0]                tick;
    logic                         start_q, stop_q, clear_q;
    logic [9:0]                   key_q;
    logic                         start_ev, stop_ev, clear_ev, key_ev;
    logic [3:0]                   key_digit;
    logic [3:0]                   s1_dec, s10_dec;
    logic [MIN_DIGITS-1:0][3:0]   mins_dec;
    logic                         borrow, dec_zero, time_zero, on_win;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign start_ev = start_q & ~startn;
    assign stop_ev  = stop_q & ~stopn;
    assign clear_ev = clear_q & ~clearn;
    // $onehot rejects both the all-zero and multi-key patterns
    assign key_ev   = (key_q == '0) && $onehot(keypad);

    always_comb begin
        key_digit = '0;
        for (int k = 0; k < 10; k++)
            if (keypad[k]) key_digit = 4'(k);
    end

    // One-second decrement with a borrow chain through the minute digits
    always_comb begin
        s1_dec  = (s1 == 4'd0) ? 4'd9 : s1 - 4'd1;
        s10_dec = (s1 != 4'd0) ? s10 : ((s10 == 4'd0) ? 4'd5 : s10 - 4'd1);
        borrow  = (s1 == 4'd0) && (s10 == 4'd0);
        for (int i = 0; i < MIN_DIGITS; i++) begin
            mins_dec[i] = !borrow ? mins[i] : ((mins[i] == 4'd0) ? 4'd9 : mins[i] - 4'd1);
            borrow      = borrow && (mins[i] == 4'd0);
        end
    end

    assign dec_zero  = (s1_dec == 4'd0) && (s10_dec == 4'd0) && (mins_dec == '0);
    assign time_zero = (s1 == 4'd0) && (s10 == 4'd0) && (mins == '0);

`ifdef MICROWAVE_POWER_LEVEL_EN
    logic [3:0] level;
    assign level  = (power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
    // tick counts down, so elapsed cycles in the current second are (TICKS_PER_SEC-1) - tick
    assign on_win = (TICKS_PER_SEC - 1 - int'(tick)) < int'(level) * (TICKS_PER_SEC / 10);
`else
    logic unused_power;
    assign unused_power = ^power_level;
    assign on_win       = 1'b1;
`endif

    assign mag_on  = (state == COOK) && door_closed && on_win;
    assign state_o = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            s1            <= '0;
            s10           <= '0;
            mins          <= '0;
            tick          <= '0;
            start_q       <= 1'b1;
            stop_q        <= 1'b1;
            clear_q       <= 1'b1;
            key_q         <= '0;
            done          <= 1'b0;
            sec_ones_segs <= ZERO_SEG;
            sec_tens_segs <= ZERO_SEG;
            mins_segs     <= {MIN_DIGITS{ZERO_SEG}};
        end else begin
            start_q       <= startn;
            stop_q        <= stopn;
            clear_q       <= clearn;
            key_q         <= keypad;
            done          <= 1'b0;
            sec_ones_segs <= seg7(s1);
            sec_tens_segs <= seg7(s10);
            for (int i = 0; i < MIN_DIGITS; i++)
                mins_segs[7*i +: 7] <= seg7(mins[i]);
            if (clear_ev) begin
                state <= IDLE;
                s1    <= '0;
                s10   <= '0;
                mins  <= '0;
                tick  <= '0;
            end else if (state == COOK) begin
                if (stop_ev || !door_closed) begin
                    state <= PAUSE;
                end else if (tick == '0) begin
                    tick <= TW'(TICKS_PER_SEC - 1);
                    s1   <= s1_dec;
                    s10  <= s10_dec;
                    mins <= mins_dec;
                    if (dec_zero) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    tick <= tick - 1'b1;
                end
            end else if (!stop_ev) begin
                if (start_ev) begin
                    if (door_closed && !time_zero) begin
                        state <= COOK;
                        // resuming from PAUSE keeps the partial second
                        if (state == IDLE) tick <= TW'(TICKS_PER_SEC - 1);
                    end
                end else if (key_ev) begin
                    s1      <= key_digit;
                    s10     <= (s1 > 4'd5) ? 4'd0 : s1;
                    mins[0] <= s10;
                    for (int i = 1; i < MIN_DIGITS; i++)
                        mins[i] <= mins[i-1];
                end
            end
        end
    end
endmodule
